// File: rtl/mem_fifo_arbiter.sv
// Two-requester round-robin write arbiter in front of a memory-core FIFO.
// Ports: clk/reset (async active-low), enable/drain_req control, depth,
//   wr0/wr1 valid/data/ready writers, rd_valid/rd_data/rd_ready consumer,
//   mem_* core controls and status, occupancy, drain_done, sync_err.
module mem_fifo_arbiter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              drain_req,
    input  logic [CNT_W-1:0]  depth,
    input  logic              wr0_valid,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_ready,
    input  logic              wr1_valid,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_valid_out,
    input  logic              mem_full,
    input  logic              mem_empty,
    output logic [CNT_W-1:0]  occupancy,
    output logic              drain_done,
    output logic              sync_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic              last;
    logic [1:0]        inflight;
    logic [1:0]        skid_cnt;
    logic [DATA_W-1:0] skid0;
    logic [DATA_W-1:0] skid1;

    logic              can_wr;
    logic              gnt0;
    logic              gnt1;
    logic              pop;
    logic              push;
    logic [1:0]        keep;
    logic [2:0]        out_cnt;

    // last==1 means wr1 won most recently, so wr0 takes the next tie
    assign can_wr = (state == RUN) && (occupancy < depth) && !mem_full;
    assign gnt0   = can_wr && wr0_valid && (!wr1_valid || last);
    assign gnt1   = can_wr && wr1_valid && (!wr0_valid || !last);

    assign wr0_ready   = gnt0;
    assign wr1_ready   = gnt1;
    assign mem_wen     = gnt0 || gnt1;
    assign mem_data_in = gnt0 ? wr0_data : (gnt1 ? wr1_data : '0);

    // reads in flight plus buffered entries never exceed the skid depth
    assign out_cnt = {1'b0, inflight} + {1'b0, skid_cnt};
    assign mem_ren = (state != IDLE) && (occupancy != '0)
                     && !mem_empty && (out_cnt < 3'd2);

    assign rd_valid = (skid_cnt != 2'd0);
    assign rd_data  = rd_valid ? skid0 : '0;

    assign pop  = rd_valid && rd_ready;
    assign push = mem_valid_out && (inflight != 2'd0);
    assign keep = skid_cnt - {1'b0, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            drain_done <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (enable)
                        state <= RUN;
                end
                RUN: begin
                    if (drain_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if ((occupancy == '0) && (inflight == 2'd0)
                        && (skid_cnt == 2'd0)) begin
                        state      <= IDLE;
                        drain_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
            inflight  <= 2'd0;
            skid_cnt  <= 2'd0;
            skid0     <= '0;
            skid1     <= '0;
            last      <= 1'b1;
            sync_err  <= 1'b0;
        end else begin
            if (mem_wen)
                last <= gnt1;

            if (mem_wen && !mem_ren)
                occupancy <= occupancy + CNT_W'(1);
            else if (!mem_wen && mem_ren)
                occupancy <= occupancy - CNT_W'(1);

            inflight <= inflight + {1'b0, mem_ren} - {1'b0, push};

            // shift on pop, then land the returning word behind what remains
            if (pop)
                skid0 <= skid1;
            if (push) begin
                if (keep == 2'd0)
                    skid0 <= mem_data_out;
                else
                    skid1 <= mem_data_out;
            end
            skid_cnt <= keep + {1'b0, push};

            if ((mem_valid_out && (inflight == 2'd0))
                || (!mem_empty && (occupancy == '0)))
                sync_err <= 1'b1;
        end
    end

endmodule
